// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: shadow entry, flush vector and the
// regfile forwarding code. Entry rd is sized for the widest supported REG_AW.
package hazard_pkg;

  localparam int HZ_RD_W     = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic               valid;
    logic [HZ_RD_W-1:0] rd;
    logic               is_load;
  } entry_t;

  typedef struct packed {
    logic if_s;
    logic id_s;
    logic ex_s;
    logic mem_s;
  } flush_vec_t;

  // A redirect kills the fetch too; an exception/xRET keeps the handler fetch.
  function automatic flush_vec_t flush_vector(input logic redirect, input logic excep);
    flush_vec_t v;
    v.if_s  = redirect;
    v.id_s  = redirect | excep;
    v.ex_s  = redirect | excep;
    v.mem_s = redirect | excep;
    return v;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-side bundle of the hazard scoreboard. The mul/div handshake exists only
// when HAZARD_MULDIV_EN is defined.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int FWD_W  = 2,
  parameter int CNT_W  = 16
);
  logic              i_id_valid;
  logic [REG_AW-1:0] i_id_rs1;
  logic [REG_AW-1:0] i_id_rs2;
  logic [REG_AW-1:0] i_id_rd;
  logic              i_id_wen;
  logic              i_id_is_load;
  logic              i_redirect;
  logic              i_excep_or_ret;
  logic [FWD_W-1:0]  o_fwd_sel_a;
  logic [FWD_W-1:0]  o_fwd_sel_b;
  logic              o_stall_if;
  logic              o_stall_id;
  logic              o_flush_if;
  logic              o_flush_id;
  logic              o_flush_ex;
  logic              o_flush_mem;
  logic [CNT_W-1:0]  o_stall_cycles;
`ifdef HAZARD_MULDIV_EN
  logic              i_md_issue;
  logic              i_md_done;

  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_rd, i_id_wen, i_id_is_load,
           i_redirect, i_excep_or_ret, i_md_issue, i_md_done,
    input  o_fwd_sel_a, o_fwd_sel_b, o_stall_if, o_stall_id, o_flush_if,
           o_flush_id, o_flush_ex, o_flush_mem, o_stall_cycles
  );

  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_rd, i_id_wen, i_id_is_load,
           i_redirect, i_excep_or_ret, i_md_issue, i_md_done,
    output o_fwd_sel_a, o_fwd_sel_b, o_stall_if, o_stall_id, o_flush_if,
           o_flush_id, o_flush_ex, o_flush_mem, o_stall_cycles
  );
`else
  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_rd, i_id_wen, i_id_is_load,
           i_redirect, i_excep_or_ret,
    input  o_fwd_sel_a, o_fwd_sel_b, o_stall_if, o_stall_id, o_flush_if,
           o_flush_id, o_flush_ex, o_flush_mem, o_stall_cycles
  );

  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_rd, i_id_wen, i_id_is_load,
           i_redirect, i_excep_or_ret,
    output o_fwd_sel_a, o_fwd_sel_b, o_stall_if, o_stall_id, o_flush_if,
           o_flush_id, o_flush_ex, o_flush_mem, o_stall_cycles
  );
`endif
endinterface

// File: rtl/hazard_scoreboard_match.sv
// Finds the youngest shadow entry that produces source register i_rs.
// Index 0 means no in-flight producer, so the operand comes from the regfile.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5,
  parameter int FWD_W  = $clog2(DEPTH + 1)
) (
  input  entry_t [DEPTH:1]   i_shadow,
  input  logic [REG_AW-1:0]  i_rs,
  output logic [FWD_W-1:0]   o_idx,
  output logic               o_is_load
);

  // Scan oldest to youngest so the smallest matching stage wins.
  always_comb begin
    o_idx     = FWD_W'(FWD_REGFILE);
    o_is_load = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (i_shadow[k].valid && (i_shadow[k].rd == HZ_RD_W'(i_rs)) && (i_rs != '0)) begin
        o_idx     = FWD_W'(k);
        o_is_load = i_shadow[k].is_load;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit beside ID: forwarding selects, load-use stalls, prioritised flushes
// and a stall counter. Define HAZARD_MULDIV_EN to block mul/div dependents.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH            = 3,
  parameter int REG_AW           = 5,
  parameter int LOAD_READY_STAGE = 2,
  parameter int CNT_W            = 16
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave bus
);

  localparam int FWD_W = $clog2(DEPTH + 1);

  entry_t [DEPTH:1] r_shadow;
  logic [CNT_W-1:0] r_stallCnt;

  logic [FWD_W-1:0] w_idxA;
  logic [FWD_W-1:0] w_idxB;
  logic             w_loadA;
  logic             w_loadB;
  logic             w_luA;
  logic             w_luB;
  logic             w_mdStall;
  logic             w_mdIssue;
  logic             w_anyFlush;
  logic             w_stall;
  flush_vec_t       w_flush;
  entry_t           w_newEntry;

  hazard_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .FWD_W(FWD_W)) u_match_a (
    .i_shadow  (r_shadow),
    .i_rs      (bus.i_id_rs1),
    .o_idx     (w_idxA),
    .o_is_load (w_loadA)
  );

  hazard_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .FWD_W(FWD_W)) u_match_b (
    .i_shadow  (r_shadow),
    .i_rs      (bus.i_id_rs2),
    .o_idx     (w_idxB),
    .o_is_load (w_loadB)
  );

  assign w_luA = w_loadA && (w_idxA != '0) && (w_idxA < FWD_W'(LOAD_READY_STAGE));
  assign w_luB = w_loadB && (w_idxB != '0) && (w_idxB < FWD_W'(LOAD_READY_STAGE));

`ifdef HAZARD_MULDIV_EN
  logic              r_mdBusy;
  logic [REG_AW-1:0] r_mdRd;

  assign w_mdIssue = bus.i_md_issue;
  assign w_mdStall = r_mdBusy &&
                     (((bus.i_id_rs1 == r_mdRd) && (bus.i_id_rs1 != '0)) ||
                      ((bus.i_id_rs2 == r_mdRd) && (bus.i_id_rs2 != '0)) ||
                      bus.i_md_issue);

  // A flushed issue never reaches the unit, so it must not leave busy set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mdBusy <= 1'b0;
      r_mdRd   <= '0;
    end else if (w_anyFlush && bus.i_md_issue) begin
      r_mdBusy <= 1'b0;
    end else if (bus.i_md_issue && !w_stall) begin
      r_mdBusy <= 1'b1;
      r_mdRd   <= bus.i_id_rd;
    end else if (bus.i_md_done) begin
      r_mdBusy <= 1'b0;
    end
  end
`else
  assign w_mdIssue = 1'b0;
  assign w_mdStall = 1'b0;
`endif

  assign w_flush    = flush_vector(bus.i_redirect, bus.i_excep_or_ret);
  assign w_anyFlush = w_flush.id_s;
  assign w_stall    = (w_luA || w_luB || w_mdStall) && !w_anyFlush;

  // Mul/div results return through the regfile, so they never enter the shadow.
  assign w_newEntry.valid   = bus.i_id_valid && bus.i_id_wen && !w_mdIssue;
  assign w_newEntry.rd      = HZ_RD_W'(bus.i_id_rd);
  assign w_newEntry.is_load = bus.i_id_is_load;

  always_comb begin
    bus.o_fwd_sel_a    = '0;
    bus.o_fwd_sel_b    = '0;
    bus.o_stall_if     = 1'b0;
    bus.o_stall_id     = 1'b0;
    bus.o_flush_if     = 1'b0;
    bus.o_flush_id     = 1'b0;
    bus.o_flush_ex     = 1'b0;
    bus.o_flush_mem    = 1'b0;
    bus.o_stall_cycles = '0;
    if (!reset) begin
      bus.o_fwd_sel_a    = w_luA ? FWD_W'(FWD_REGFILE) : w_idxA;
      bus.o_fwd_sel_b    = w_luB ? FWD_W'(FWD_REGFILE) : w_idxB;
      bus.o_stall_if     = w_stall;
      bus.o_stall_id     = w_stall;
      bus.o_flush_if     = w_flush.if_s;
      bus.o_flush_id     = w_flush.id_s;
      bus.o_flush_ex     = w_flush.ex_s;
      bus.o_flush_mem    = w_flush.mem_s;
      bus.o_stall_cycles = r_stallCnt;
    end
  end

  // On a flush only the oldest surviving instruction keeps moving toward WB.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= '0;
    end else if (w_anyFlush) begin
      for (int k = 1; k < DEPTH; k++) begin
        r_shadow[k] <= '0;
      end
      r_shadow[DEPTH] <= r_shadow[DEPTH-1];
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        r_shadow[k] <= r_shadow[k-1];
      end
      r_shadow[1] <= w_stall ? entry_t'('0) : w_newEntry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stallCnt <= '0;
    end else if (w_stall && (r_stallCnt != '1)) begin
      r_stallCnt <= r_stallCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: an in-flight instruction list model
// checked every cycle, plus literal checks at the directed scenarios.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int DEPTH = 3;
  localparam int REG_AW = 5;
  localparam int LRS = 2;
  localparam int CNT_W = 16;
  localparam int FWD_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(REG_AW), .FWD_W(FWD_W), .CNT_W(CNT_W)) bus ();

  hazard_scoreboard #(
    .DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_READY_STAGE(LRS), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int rd;
    bit isLoad;
    int stage;
  } inflight_t;

  inflight_t flight[$];
  int modelCnt = 0;
`ifdef HAZARD_MULDIV_EN
  bit mdBusy = 0;
  int mdRd = 0;
  bit tbMdIssue = 0;
  bit tbMdDone = 0;
`endif

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input int rd, input bit wen,
                               input bit ld, input int rs1, input int rs2,
                               input bit redir, input bit exc);
    @(posedge clk);
    #1;
    reset = rst;
    bus.i_id_valid = v;
    bus.i_id_rd = REG_AW'(rd);
    bus.i_id_wen = wen;
    bus.i_id_is_load = ld;
    bus.i_id_rs1 = REG_AW'(rs1);
    bus.i_id_rs2 = REG_AW'(rs2);
    bus.i_redirect = redir;
    bus.i_excep_or_ret = exc;
`ifdef HAZARD_MULDIV_EN
    bus.i_md_issue = tbMdIssue;
    bus.i_md_done = tbMdDone;
`endif
  endtask

  // Youngest in-flight producer of rs: smallest stage number, 0 if none.
  function automatic void findProducer(input int rs, output int stage, output bit isLoad);
    stage = 0;
    isLoad = 0;
    if (rs == 0) return;
    foreach (flight[i]) begin
      if (flight[i].rd == rs && (stage == 0 || flight[i].stage < stage)) begin
        stage = flight[i].stage;
        isLoad = flight[i].isLoad;
      end
    end
  endfunction

  // Per-cycle model comparison at negedge, model advance at posedge.
  initial begin : compareProc
    int sA, sB, eFwdA, eFwdB, rs1, rs2;
    bit lA, lB, luA, luB, mdSt, anyFlush, eStall, redir;
    inflight_t nq[$];
    forever begin
      @(negedge clk);
      rs1 = int'(bus.i_id_rs1);
      rs2 = int'(bus.i_id_rs2);
      findProducer(rs1, sA, lA);
      findProducer(rs2, sB, lB);
      luA = lA && sA > 0 && sA < LRS;
      luB = lB && sB > 0 && sB < LRS;
      mdSt = 0;
`ifdef HAZARD_MULDIV_EN
      mdSt = mdBusy && ((rs1 == mdRd && rs1 != 0) || (rs2 == mdRd && rs2 != 0) || bus.i_md_issue);
`endif
      redir = bus.i_redirect;
      anyFlush = bus.i_redirect || bus.i_excep_or_ret;
      eStall = (luA || luB || mdSt) && !anyFlush;
      eFwdA = luA ? 0 : sA;
      eFwdB = luB ? 0 : sB;
      if (reset) begin
        eStall = 0; eFwdA = 0; eFwdB = 0; redir = 0; anyFlush = 0;
      end
      checkOutput("model_fwd_sel_a", int'(bus.o_fwd_sel_a), eFwdA);
      checkOutput("model_fwd_sel_b", int'(bus.o_fwd_sel_b), eFwdB);
      checkOutput("model_stall_if", int'(bus.o_stall_if), int'(eStall));
      checkOutput("model_stall_id", int'(bus.o_stall_id), int'(eStall));
      checkOutput("model_flush_if", int'(bus.o_flush_if), int'(redir));
      checkOutput("model_flush_id", int'(bus.o_flush_id), int'(anyFlush));
      checkOutput("model_flush_ex", int'(bus.o_flush_ex), int'(anyFlush));
      checkOutput("model_flush_mem", int'(bus.o_flush_mem), int'(anyFlush));
      checkOutput("model_stall_cycles", int'(bus.o_stall_cycles), reset ? 0 : modelCnt);
      @(posedge clk);
      if (reset) begin
        flight.delete();
        modelCnt = 0;
`ifdef HAZARD_MULDIV_EN
        mdBusy = 0;
`endif
      end else begin
        if (eStall && modelCnt < (1 << CNT_W) - 1) modelCnt++;
        nq.delete();
        if (anyFlush) begin
          foreach (flight[i])
            if (flight[i].stage == DEPTH - 1) nq.push_back('{flight[i].rd, flight[i].isLoad, DEPTH});
        end else begin
          foreach (flight[i])
            if (flight[i].stage < DEPTH) nq.push_back('{flight[i].rd, flight[i].isLoad, flight[i].stage + 1});
          if (!eStall && bus.i_id_valid && bus.i_id_wen
`ifdef HAZARD_MULDIV_EN
              && !bus.i_md_issue
`endif
             )
            nq.push_back('{int'(bus.i_id_rd), bit'(bus.i_id_is_load), 1});
        end
        flight = nq;
`ifdef HAZARD_MULDIV_EN
        if (anyFlush && bus.i_md_issue) mdBusy = 0;
        else if (bus.i_md_issue && !eStall) begin mdBusy = 1; mdRd = int'(bus.i_id_rd); end
        else if (bus.i_md_done) mdBusy = 0;
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bus.i_id_valid = 1; bus.i_id_rd = 5; bus.i_id_wen = 1; bus.i_id_is_load = 1;
    bus.i_id_rs1 = 5; bus.i_id_rs2 = 5; bus.i_redirect = 1; bus.i_excep_or_ret = 0;
`ifdef HAZARD_MULDIV_EN
    bus.i_md_issue = 0; bus.i_md_done = 0;
`endif
    #4;
    checkOutput("reset_flush_if", int'(bus.o_flush_if), 0);
    checkOutput("reset_stall_cycles", int'(bus.o_stall_cycles), 0);
    applyStimulus(1, 1, 5, 1, 1, 5, 5, 0, 1);
    #3;
    checkOutput("reset_flush_id", int'(bus.o_flush_id), 0);

    // Load-use: load x5 then consumer of x5.
    applyStimulus(0, 1, 5, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 6, 1, 0, 5, 0, 0, 0);
    #3;
    checkOutput("lu_stall_if", int'(bus.o_stall_if), 1);
    checkOutput("lu_stall_id", int'(bus.o_stall_id), 1);
    checkOutput("lu_fwd_a_zero", int'(bus.o_fwd_sel_a), 0);
    applyStimulus(0, 1, 6, 1, 0, 5, 0, 0, 0);
    #3;
    checkOutput("lu_release_stall", int'(bus.o_stall_id), 0);
    checkOutput("lu_release_fwd_a", int'(bus.o_fwd_sel_a), 2);
    checkOutput("lu_stall_cycles", int'(bus.o_stall_cycles), 1);

    // Two producers of x7: youngest wins; then an x0 producer.
    applyStimulus(0, 1, 7, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 7, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 0, 7, 0, 0);
    #3;
    checkOutput("youngest_fwd_b", int'(bus.o_fwd_sel_b), 1);
    checkOutput("youngest_no_stall", int'(bus.o_stall_id), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 7, 0, 0);
    #3;
    checkOutput("x0_fwd_a", int'(bus.o_fwd_sel_a), 0);
    checkOutput("x0_skip_fwd_b", int'(bus.o_fwd_sel_b), 2);

    // Load-use coinciding with redirect.
    applyStimulus(0, 1, 10, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 11, 1, 0, 10, 0, 1, 0);
    #3;
    checkOutput("redir_flush_if", int'(bus.o_flush_if), 1);
    checkOutput("redir_flush_mem", int'(bus.o_flush_mem), 1);
    checkOutput("redir_stall_id", int'(bus.o_stall_id), 0);
    applyStimulus(0, 1, 12, 1, 1, 10, 0, 0, 0);
    #3;
    checkOutput("post_redir_fwd_a", int'(bus.o_fwd_sel_a), 0);
    checkOutput("post_redir_stall", int'(bus.o_stall_id), 0);

    // Exception over a pending load-use.
    applyStimulus(0, 1, 0, 0, 0, 12, 0, 0, 1);
    #3;
    checkOutput("exc_flush_if", int'(bus.o_flush_if), 0);
    checkOutput("exc_flush_ex", int'(bus.o_flush_ex), 1);
    checkOutput("exc_stall_if", int'(bus.o_stall_if), 0);

    // Reset asserted in the middle of a load-use stall.
    applyStimulus(0, 1, 13, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 14, 1, 0, 13, 0, 0, 0);
    #3;
    checkOutput("pre_reset_stall", int'(bus.o_stall_id), 1);
    applyStimulus(1, 1, 14, 1, 0, 13, 0, 0, 0);
    #3;
    checkOutput("midreset_stall_if", int'(bus.o_stall_if), 0);
    checkOutput("midreset_stall_cycles", int'(bus.o_stall_cycles), 0);
    applyStimulus(0, 1, 14, 1, 0, 13, 0, 0, 0);
    #3;
    checkOutput("postreset_stall", int'(bus.o_stall_id), 0);
    checkOutput("postreset_stall_cycles", int'(bus.o_stall_cycles), 0);

    // Mixed traffic on a small register set, checked by the model only.
    for (int i = 0; i < 60; i++) begin
      applyStimulus(0, bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

`ifdef HAZARD_MULDIV_EN
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbMdIssue = 1;
    applyStimulus(0, 1, 9, 1, 0, 0, 0, 0, 0);
    #3;
    checkOutput("md_issue_no_stall", int'(bus.o_stall_id), 0);
    tbMdIssue = 0;
    applyStimulus(0, 1, 15, 1, 0, 9, 0, 0, 0);
    #3;
    checkOutput("md_dep_stall", int'(bus.o_stall_id), 1);
    applyStimulus(0, 1, 15, 1, 0, 9, 0, 0, 0);
    tbMdDone = 1;
    applyStimulus(0, 1, 15, 1, 0, 9, 0, 0, 0);
    #3;
    checkOutput("md_done_cycle_stall", int'(bus.o_stall_id), 1);
    tbMdDone = 0;
    applyStimulus(0, 1, 15, 1, 0, 9, 0, 0, 0);
    #3;
    checkOutput("md_release_stall", int'(bus.o_stall_id), 0);
    checkOutput("md_release_fwd_a", int'(bus.o_fwd_sel_a), 0);
`endif

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
